// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : uart_pkg
//  Brief   : Shared UART types and defaults for the TX feeder and FIFO
//  Revision: 1.0  initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    FEED_IDLE = 2'd0,
    FEED_SEND = 2'd1,
    FEED_GAP  = 2'd2
  } feed_state_t;

  localparam int DATA_W_DEF = 8;

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : uart_sync_fifo
//  Brief   : Single-clock FIFO with explicit level count and synchronous flush
//  Revision: 1.0  initial release
// ============================================================================
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  input  logic                     flush
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   c_full_lvl = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] c_ptr_one  = AW'(1);
  localparam logic [AW:0]   c_lvl_one  = (AW+1)'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              w_push;
  logic              w_pop;

  assign empty  = (r_level == '0);
  assign full   = (r_level == c_full_lvl);
  assign level  = r_level;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // A push in the flush cycle is dropped, so the array write is gated too.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_lvl_one;
        2'b01:   r_level <= r_level - c_lvl_one;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module  : uart_tx_feeder
//  Brief   : Buffers host bytes and hands them one at a time to the UART TX
//  Revision: 1.0  initial release
// ============================================================================
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     flush,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_done,
  input  logic                     tx_err,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     busy,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  feed_state_t       r_state;
  logic              r_tx_start;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_done_q;
  logic [CNT_W-1:0]  r_err_cnt;
  logic [DATA_W-1:0] w_head;
  logic              w_pop;
  logic              w_done_rise;

  assign w_pop       = (r_state == FEED_IDLE) && !empty && !flush;
  assign w_done_rise = tx_done && !r_tx_done_q;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_valid),
    .pop   (w_pop),
    .din   (wr_data),
    .dout  (w_head),
    .level (level),
    .empty (empty),
    .full  (full),
    .flush (flush)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FEED_IDLE;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_tx_done_q <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_tx_done_q <= tx_done;
      case (r_state)
        FEED_IDLE: begin
          if (w_pop) begin
            r_tx_data  <= w_head;
            r_tx_start <= 1'b1;
            r_state    <= FEED_SEND;
          end
        end
        FEED_SEND: begin
          // Only a rising edge ends the frame; a level left over from the previous frame does not.
          if (w_done_rise) begin
            r_tx_start <= 1'b0;
            r_state    <= FEED_GAP;
            if (tx_err && (r_err_cnt != '1)) begin
              r_err_cnt <= r_err_cnt + c_cnt_one;
            end
          end
        end
        FEED_GAP: begin
          if (!tx_done) r_state <= FEED_IDLE;
        end
        default: begin
          r_tx_start <= 1'b0;
          r_state    <= FEED_IDLE;
        end
      endcase
    end
  end

  assign wr_ready = !full;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign busy     = (r_state != FEED_IDLE);
  assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_uart_tx_feeder
//  Brief   : Self-checking bench for uart_tx_feeder with a behavioural TX sink
//  Revision: 1.0  initial release
// ============================================================================
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid, wr_ready, flush;
  logic [7:0] wr_data;
  logic       tx_start, tx_done, tx_err;
  logic [7:0] tx_data;
  logic [4:0] level;
  logic       empty, full, busy;
  logic [7:0] err_cnt;

  logic sink_done, sink_err, man_done, man_err;
  bit   sink_en, sink_err_rand, sink_err_force;

  assign tx_done = sink_done | man_done;
  assign tx_err  = sink_err | man_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         exp_err;

  typedef struct {
    logic [7:0] data;
    bit         err;
    logic [7:0] exp_rx;
    logic [7:0] exp_cnt;
  } vec_t;
  vec_t vecs[4];

  uart_tx_feeder #(.DEPTH(16), .DATA_W(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .flush    (flush),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .tx_err   (tx_err),
    .level    (level),
    .empty    (empty),
    .full     (full),
    .busy     (busy),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    while (!wr_ready && n < 500) begin
      tick();
      n++;
    end
    if (!wr_ready) begin
      failures++;
      $display("FAIL push_timeout: wr_ready stuck low for byte %0h", b);
    end else begin
      wr_valid = 1'b1;
      wr_data  = b;
      exp_q.push_back(b);
      tick();
      wr_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int n);
    int c = 0;
    while (!(rx_q.size() >= n && !busy && !tx_done && empty) && c < 20000) begin
      tick();
      c++;
    end
    if (c >= 20000) begin
      failures++;
      $display("FAIL drain_timeout: received %0d expected %0d", rx_q.size(), n);
    end
  endtask

  // Behavioural UART TX: accepts a frame when tx_start is seen, reports done after a random delay.
  initial begin
    logic [7:0] b;
    int dly, hold;
    bit e;
    sink_done = 1'b0;
    sink_err  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (sink_en && tx_start) begin
        b   = tx_data;
        dly = $urandom_range(0, 3);
        for (int i = 0; i < dly; i++) begin
          @(posedge clk);
          #2;
          check("start_held", tx_start, 1'b1);
          check("data_stable", tx_data, b);
        end
        e = sink_err_rand ? bit'($urandom_range(0, 1)) : sink_err_force;
        sink_done = 1'b1;
        sink_err  = e;
        rx_q.push_back(b);
        if (e && exp_err != 255) exp_err++;
        hold = $urandom_range(1, 3);
        @(posedge clk);
        #2;
        sink_err = 1'b0;
        check("start_drop", tx_start, 1'b0);
        for (int i = 1; i < hold; i++) begin
          @(posedge clk);
          #2;
          check("gap_no_restart", tx_start, 1'b0);
        end
        sink_done = 1'b0;
      end
    end
  end

  initial begin
    int rises;
    logic prev;
    logic [7:0] d;
    bit v;

    vecs[0] = '{data: 8'h11, err: 1'b0, exp_rx: 8'h11, exp_cnt: 8'd0};
    vecs[1] = '{data: 8'h22, err: 1'b0, exp_rx: 8'h22, exp_cnt: 8'd0};
    vecs[2] = '{data: 8'h33, err: 1'b1, exp_rx: 8'h33, exp_cnt: 8'd1};
    vecs[3] = '{data: 8'h44, err: 1'b0, exp_rx: 8'h44, exp_cnt: 8'd1};

    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; flush = 1'b0;
    man_done = 1'b0; man_err = 1'b0;
    sink_en = 1'b0; sink_err_rand = 1'b0; sink_err_force = 1'b0;
    exp_err = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_level", level, 5'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err_cnt", err_cnt, 8'd0);
    check("rst_wr_ready", wr_ready, 1'b1);

    // Single byte, latency and no bypass
    wr_valid = 1'b1; wr_data = 8'hAF;
    tick();
    wr_valid = 1'b0;
    check("lat1_tx_start", tx_start, 1'b0);
    check("lat1_level", level, 5'd1);
    tick();
    check("lat2_tx_start", tx_start, 1'b1);
    check("lat2_tx_data", tx_data, 8'hAF);
    check("lat2_level", level, 5'd0);
    check("lat2_busy", busy, 1'b1);
    repeat (3) begin
      tick();
      check("send_hold", tx_start, 1'b1);
    end
    man_done = 1'b1;
    tick();
    check("done_drop", tx_start, 1'b0);
    check("done_err_cnt", err_cnt, 8'd0);
    tick();
    check("gap_busy", busy, 1'b1);
    man_done = 1'b0;
    tick();
    check("gap_exit", busy, 1'b0);
    check("gap_tx_start", tx_start, 1'b0);

    // Table-driven frames with one forced error
    sink_en = 1'b1;
    foreach (vecs[i]) begin
      rx_q.delete();
      sink_err_force = vecs[i].err;
      push_byte(vecs[i].data);
      wait_drain(1);
      check("vec_rx", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, vecs[i].exp_rx);
      check("vec_err_cnt", err_cnt, vecs[i].exp_cnt);
    end
    sink_err_force = 1'b0;

    // Fill to full while the sink stalls, then drain in order
    sink_en = 1'b0;
    rx_q.delete(); exp_q.delete();
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    check("fill_full", full, 1'b1);
    check("fill_wr_ready", wr_ready, 1'b0);
    check("fill_level", level, 5'd16);
    wr_valid = 1'b1; wr_data = 8'hEE;
    tick();
    wr_valid = 1'b0;
    check("held_off_level", level, 5'd16);
    sink_en = 1'b1;
    wait_drain(17);
    check("fill_rx_count", rx_q.size(), 17);
    foreach (exp_q[i]) if (i < rx_q.size()) check("fill_order", rx_q[i], exp_q[i]);

    // Error counter saturation
    rx_q.delete(); exp_q.delete();
    sink_err_force = 1'b1;
    for (int i = 0; i < 260; i++) push_byte(8'(i));
    wait_drain(260);
    sink_err_force = 1'b0;
    check("sat_err_cnt", err_cnt, 8'hFF);

    // Async reset in the middle of a frame
    sink_en = 1'b0;
    repeat (4) tick();
    rx_q.delete(); exp_q.delete();
    push_byte(8'hB1);
    push_byte(8'hB2);
    check("pre_rst_start", tx_start, 1'b1);
    check("pre_rst_level", level, 5'd1);
    #2 rst = 1'b1;
    #1;
    check("async_tx_start", tx_start, 1'b0);
    check("async_level", level, 5'd0);
    check("async_busy", busy, 1'b0);
    check("async_err_cnt", err_cnt, 8'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_err = 0;
    sink_en = 1'b1;
    push_byte(8'hC3);
    wait_drain(1);
    check("post_rst_rx", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hC3);

    // Flush during the first of five frames
    sink_en = 1'b0;
    rx_q.delete();
    for (int i = 0; i < 5; i++) push_byte(8'hA1 + 8'(i));
    check("pre_flush_level", level, 5'd4);
    flush = 1'b1; wr_valid = 1'b1; wr_data = 8'h5A;
    tick();
    flush = 1'b0; wr_valid = 1'b0;
    check("flush_level", level, 5'd0);
    check("flush_empty", empty, 1'b1);
    check("flush_keeps_start", tx_start, 1'b1);
    check("flush_keeps_data", tx_data, 8'hA1);
    sink_en = 1'b1;
    wait_drain(1);
    rises = 0; prev = tx_start;
    repeat (20) begin
      tick();
      if (tx_start && !prev) rises++;
      prev = tx_start;
    end
    check("flush_rx_count", rx_q.size(), 1);
    check("flush_rx_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hA1);
    check("flush_no_more_start", rises, 0);

    // Randomized traffic against the queue model
    rx_q.delete(); exp_q.delete();
    sink_err_rand = 1'b1;
    for (int c = 0; c < 400; c++) begin
      v = bit'($urandom_range(0, 1));
      d = 8'($urandom);
      wr_valid = v; wr_data = d;
      if (v && wr_ready) exp_q.push_back(d);
      tick();
    end
    wr_valid = 1'b0;
    wait_drain(exp_q.size());
    check("rand_rx_count", rx_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < rx_q.size()) check("rand_order", rx_q[i], exp_q[i]);
    check("rand_err_cnt", err_cnt, 8'(exp_err));
    check("rand_level", level, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
